// File: rtl/tone_gen_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tone_gen_param_if                                           |
// | Description : Control/status bundle between the switch/sequencer logic    |
// |               and the parametrised tone generator.                        |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface tone_gen_param_if #(
  parameter int DIV_W = 32,
  parameter int SEL_W = 3,
  parameter int OCT_W = 2
);
  logic             enable;
  logic [SEL_W-1:0] note_sel;
  logic [OCT_W-1:0] octave;
  logic             tbl_we;
  logic [SEL_W-1:0] tbl_addr;
  logic [DIV_W-1:0] tbl_wdata;
  logic             tone_out;
  logic [DIV_W-1:0] active_div;
  logic             note_update;

  // Sequencer side: issues note requests and table writes.
  modport master (
    output enable, note_sel, octave, tbl_we, tbl_addr, tbl_wdata,
    input  tone_out, active_div, note_update
  );

  // Generator side.
  modport slave (
    input  enable, note_sel, octave, tbl_we, tbl_addr, tbl_wdata,
    output tone_out, active_div, note_update
  );
endinterface
`default_nettype wire

// File: rtl/tone_gen_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tone_gen_param                                              |
// | Description : Square-wave tone generator with a run-time writable         |
// |               half-period table and octave shift. Note changes are only   |
// |               applied at half-period boundaries so the output never       |
// |               produces a runt pulse.                                      |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tone_gen_param #(
  parameter int DIV_W     = 32,
  parameter int NUM_NOTES = 8,
  parameter int SEL_W     = 3,
  parameter int OCT_W     = 2
) (
  input logic             clk,
  input logic             rst_n,
  tone_gen_param_if.slave bus
);

  // Reset contents of the divider table; entries past the classic eight are silent.
  function automatic logic [DIV_W-1:0] default_div(input int idx);
    logic [15:0] v;
    case (idx)
      0:       v = 16'hBAA2;
      1:       v = 16'hA646;
      2:       v = 16'h9422;
      3:       v = 16'h8BE8;
      4:       v = 16'h7CB8;
      5:       v = 16'h6EFA;
      6:       v = 16'h62F2;
      7:       v = 16'h5D5C;
      default: v = 16'h0000;
    endcase
    return DIV_W'(v);
  endfunction

  logic [DIV_W-1:0] tbl_q [NUM_NOTES];
  logic [DIV_W-1:0] req_div_q,    req_div_d;
  logic [DIV_W-1:0] active_div_q, active_div_d;
  logic [DIV_W-1:0] cnt_q,        cnt_d;
  logic             tone_q,       tone_d;
  logic             note_update_q, note_update_d;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [OCT_W-1:0] w_shift;
  logic             w_running;
  logic             w_toggle;
  logic             w_load;

  assign w_shift = bus.octave;

  // A power-of-two table cannot be addressed out of range, so skip the compare.
  if (NUM_NOTES == (1 << SEL_W)) begin : g_full_table
    assign w_wr_ok = bus.tbl_we;
    assign w_rd_ok = 1'b1;
  end else begin : g_part_table
    assign w_wr_ok = bus.tbl_we && (int'(bus.tbl_addr) < NUM_NOTES);
    assign w_rd_ok = (int'(bus.note_sel) < NUM_NOTES);
  end

  // Divider table: defaults on reset, out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        tbl_q[i] <= default_div(i);
      end
    end else if (w_wr_ok) begin
      tbl_q[bus.tbl_addr] <= bus.tbl_wdata;
    end
  end

  // Next-state logic: requested divider, half-period counter and load decision.
  always_comb begin
    req_div_d     = w_rd_ok ? (tbl_q[bus.note_sel] >> w_shift) : '0;
    w_running     = bus.enable && (active_div_q != '0);
    w_toggle      = w_running && (cnt_q == active_div_q - DIV_W'(1));
    // Muted or silent states are load points every cycle, as is each toggle.
    w_load        = w_toggle || !w_running;
    cnt_d         = cnt_q;
    tone_d        = tone_q;
    if (!w_running) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (w_toggle) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d  = cnt_q + DIV_W'(1);
    end
    active_div_d  = w_load ? req_div_q : active_div_q;
    note_update_d = w_load && (req_div_q != active_div_q);
  end

  // Registered state; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_div_q     <= '0;
      active_div_q  <= '0;
      cnt_q         <= '0;
      tone_q        <= 1'b0;
      note_update_q <= 1'b0;
    end else begin
      req_div_q     <= req_div_d;
      active_div_q  <= active_div_d;
      cnt_q         <= cnt_d;
      tone_q        <= tone_d;
      note_update_q <= note_update_d;
    end
  end

  assign bus.tone_out    = tone_q;
  assign bus.active_div  = active_div_q;
  assign bus.note_update = note_update_q;

endmodule
`default_nettype wire
